// File: rtl/id_ex_reg_pkg.sv
// rtl/id_ex_reg_pkg.sv - control-word layout and codes shared by the ID/EX register
package id_ex_reg_pkg;

  localparam int CTRL_NEXT_PC_SRC_BIT = 19;
  localparam int CTRL_WB_BIT          = 1;
  localparam int CTRL_MEM_TO_REG_BIT  = 0;

  localparam logic CODE_MAIN_CTR_ENABLE  = 1'b1;
  localparam logic CODE_MAIN_CTR_DISABLE = 1'b0;

  localparam logic CODE_MAIN_CTR_MEM_TO_REG_ALU_RESULT = 1'b0;
  localparam logic CODE_MAIN_CTR_MEM_TO_REG_MEM_RESULT = 1'b1;

  // Every field NOTHING/DISABLE, next_pc_src = SEQ
  localparam logic [19:0] CODE_ID_EX_BUBBLE = 20'b0;

endpackage

// File: rtl/id_ex_reg_load_use_detector.sv
// rtl/id_ex_reg_load_use_detector.sv - combinational load-use hazard compare
module id_ex_reg_load_use_detector
  import id_ex_reg_pkg::*;
#(
  parameter int NB_REG = 5
) (
  input  logic              ex_wb,
  input  logic              ex_mem_to_reg,
  input  logic [NB_REG-1:0] ex_rt,
  input  logic [NB_REG-1:0] id_rs,
  input  logic [NB_REG-1:0] id_rt,
  output logic              hazard
);

  logic is_load;
  logic reg_match;

  // r0 is hardwired zero, so a load into it never creates a dependency
  assign is_load   = (ex_wb == CODE_MAIN_CTR_ENABLE) &&
                     (ex_mem_to_reg == CODE_MAIN_CTR_MEM_TO_REG_MEM_RESULT) &&
                     (ex_rt != '0);
  assign reg_match = (ex_rt == id_rs) || (ex_rt == id_rt);
  assign hazard    = is_load && reg_match;

endmodule

// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - ID/EX pipeline register with load-use bubble insertion
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int NB_CTRL = 20,
  parameter int NB_CNT  = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_halt,
  input  logic               i_flush,
  input  logic [NB_CTRL-1:0] i_ctrl_regs,
  input  logic [NB_DATA-1:0] i_bus_a,
  input  logic [NB_DATA-1:0] i_bus_b,
  input  logic [NB_DATA-1:0] i_next_seq_pc,
  input  logic [NB_REG-1:0]  i_rs,
  input  logic [NB_REG-1:0]  i_rt,
  input  logic [NB_REG-1:0]  i_rd,
  input  logic [4:0]         i_shamt,
  input  logic [15:0]        i_inm,
  output logic [NB_CTRL-1:0] o_ctrl_regs,
  output logic [NB_DATA-1:0] o_bus_a,
  output logic [NB_DATA-1:0] o_bus_b,
  output logic [NB_DATA-1:0] o_next_seq_pc,
  output logic [NB_REG-1:0]  o_rs,
  output logic [NB_REG-1:0]  o_rt,
  output logic [NB_REG-1:0]  o_rd,
  output logic [4:0]         o_shamt,
  output logic [15:0]        o_inm,
  output logic               o_stall,
  output logic [NB_CNT-1:0]  o_bubble_count
);

  logic hazard;
  logic insert_bubble;

  id_ex_reg_load_use_detector #(
    .NB_REG(NB_REG)
  ) u_load_use_detector (
    .ex_wb         (o_ctrl_regs[CTRL_WB_BIT]),
    .ex_mem_to_reg (o_ctrl_regs[CTRL_MEM_TO_REG_BIT]),
    .ex_rt         (o_rt),
    .id_rs         (i_rs),
    .id_rt         (i_rt),
    .hazard        (hazard)
  );

  assign o_stall       = hazard && !i_halt && !i_flush;
  assign insert_bubble = i_flush || hazard;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_ctrl_regs    <= NB_CTRL'(CODE_ID_EX_BUBBLE);
      o_bus_a        <= '0;
      o_bus_b        <= '0;
      o_next_seq_pc  <= '0;
      o_rs           <= '0;
      o_rt           <= '0;
      o_rd           <= '0;
      o_shamt        <= '0;
      o_inm          <= '0;
      o_bubble_count <= '0;
    end else if (i_halt) begin
      // debug freeze: hold everything, including the counter
    end else if (insert_bubble) begin
      o_ctrl_regs    <= NB_CTRL'(CODE_ID_EX_BUBBLE);
      o_bus_a        <= '0;
      o_bus_b        <= '0;
      o_next_seq_pc  <= '0;
      o_rs           <= '0;
      o_rt           <= '0;
      o_rd           <= '0;
      o_shamt        <= '0;
      o_inm          <= '0;
      if (o_bubble_count != '1) begin
        o_bubble_count <= o_bubble_count + 1'b1;
      end
    end else begin
      o_ctrl_regs    <= i_ctrl_regs;
      o_bus_a        <= i_bus_a;
      o_bus_b        <= i_bus_b;
      o_next_seq_pc  <= i_next_seq_pc;
      o_rs           <= i_rs;
      o_rt           <= i_rt;
      o_rd           <= i_rd;
      o_shamt        <= i_shamt;
      o_inm          <= i_inm;
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
// tb/tb_id_ex_reg.sv - directed self-checking bench for id_ex_reg
module tb_id_ex_reg;

  localparam logic [19:0] CTRL_ADDI = 20'h00846;
  localparam logic [19:0] CTRL_ADD  = 20'h00042;
  localparam logic [19:0] CTRL_LW   = 20'h00C83;

  logic        clk = 1'b0;
  logic        reset, halt, flush;
  logic [19:0] ctrl_in;
  logic [31:0] bus_a_in, bus_b_in, pc_in;
  logic [4:0]  rs_in, rt_in, rd_in, shamt_in;
  logic [15:0] inm_in;

  logic [19:0] ctrl_out;
  logic [31:0] bus_a_out, bus_b_out, pc_out;
  logic [4:0]  rs_out, rt_out, rd_out, shamt_out;
  logic [15:0] inm_out;
  logic        stall;
  logic [15:0] count;

  logic [19:0] s_ctrl;
  logic [31:0] s_bus_a, s_bus_b, s_pc;
  logic [4:0]  s_rs, s_rt, s_rd, s_shamt;
  logic [15:0] s_inm;
  logic        s_stall;
  logic [3:0]  s_count;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  id_ex_reg dut (
    .i_clk(clk), .i_reset(reset), .i_halt(halt), .i_flush(flush),
    .i_ctrl_regs(ctrl_in), .i_bus_a(bus_a_in), .i_bus_b(bus_b_in),
    .i_next_seq_pc(pc_in), .i_rs(rs_in), .i_rt(rt_in), .i_rd(rd_in),
    .i_shamt(shamt_in), .i_inm(inm_in),
    .o_ctrl_regs(ctrl_out), .o_bus_a(bus_a_out), .o_bus_b(bus_b_out),
    .o_next_seq_pc(pc_out), .o_rs(rs_out), .o_rt(rt_out), .o_rd(rd_out),
    .o_shamt(shamt_out), .o_inm(inm_out), .o_stall(stall),
    .o_bubble_count(count)
  );

  // Narrow counter instance so saturation is reachable in a few cycles
  id_ex_reg #(.NB_CNT(4)) u_sat (
    .i_clk(clk), .i_reset(reset), .i_halt(halt), .i_flush(flush),
    .i_ctrl_regs(ctrl_in), .i_bus_a(bus_a_in), .i_bus_b(bus_b_in),
    .i_next_seq_pc(pc_in), .i_rs(rs_in), .i_rt(rt_in), .i_rd(rd_in),
    .i_shamt(shamt_in), .i_inm(inm_in),
    .o_ctrl_regs(s_ctrl), .o_bus_a(s_bus_a), .o_bus_b(s_bus_b),
    .o_next_seq_pc(s_pc), .o_rs(s_rs), .o_rt(s_rt), .o_rd(s_rd),
    .o_shamt(s_shamt), .o_inm(s_inm), .o_stall(s_stall),
    .o_bubble_count(s_count)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [19:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [15:0] inm);
    ctrl_in  = c;
    bus_a_in = a;
    bus_b_in = b;
    pc_in    = 32'h0000_1004;
    rs_in    = rs;
    rt_in    = rt;
    rd_in    = rd;
    shamt_in = 5'd0;
    inm_in   = inm;
    #1;
  endtask

  initial begin
    halt  = 1'b0;
    flush = 1'b0;
    reset = 1'b1;
    ctrl_in  = 20'($urandom);
    bus_a_in = $urandom;
    bus_b_in = $urandom;
    pc_in    = $urandom;
    rs_in    = 5'($urandom);
    rt_in    = 5'($urandom);
    rd_in    = 5'($urandom);
    shamt_in = 5'($urandom);
    inm_in   = 16'($urandom);
    step();
    step();
    check("reset_ctrl", 32'(ctrl_out), 32'h0);
    check("reset_bus_a", bus_a_out, 32'h0);
    check("reset_bus_b", bus_b_out, 32'h0);
    check("reset_pc", pc_out, 32'h0);
    check("reset_fields", {12'h0, rs_out, rt_out, rd_out, shamt_out}, 32'h0);
    check("reset_inm", 32'(inm_out), 32'h0);
    check("reset_stall", 32'(stall), 32'h0);
    check("reset_count", 32'(count), 32'h0);

    // Capture
    reset = 1'b0;
    drive(CTRL_ADDI, 32'h5, 32'h9, 5'd1, 5'd2, 5'd4, 16'h7);
    shamt_in = 5'd3;
    #1;
    check("cap_stall_pre", 32'(stall), 32'h0);
    step();
    check("cap_ctrl", 32'(ctrl_out), 32'(CTRL_ADDI));
    check("cap_bus_a", bus_a_out, 32'h5);
    check("cap_bus_b", bus_b_out, 32'h9);
    check("cap_pc", pc_out, 32'h0000_1004);
    check("cap_regs", {17'h0, rs_out, rt_out, rd_out}, {17'h0, 5'd1, 5'd2, 5'd4});
    check("cap_shamt", 32'(shamt_out), 32'h3);
    check("cap_inm", 32'(inm_out), 32'h7);
    check("cap_stall_post", 32'(stall), 32'h0);

    // Load-use: LW rt=3 in EX, ID reads rs=3
    drive(CTRL_LW, 32'h200, 32'h0, 5'd1, 5'd3, 5'd0, 16'h10);
    step();
    drive(CTRL_ADD, 32'hAA, 32'hBB, 5'd3, 5'd5, 5'd6, 16'h0);
    check("lu_stall", 32'(stall), 32'h1);
    step();
    check("lu_bubble_ctrl", 32'(ctrl_out), 32'h0);
    check("lu_bubble_bus_a", bus_a_out, 32'h0);
    check("lu_bubble_rt", 32'(rt_out), 32'h0);
    check("lu_count", 32'(count), 32'h1);
    check("lu_stall_clear", 32'(stall), 32'h0);
    step();
    check("lu_resume_ctrl", 32'(ctrl_out), 32'(CTRL_ADD));
    check("lu_resume_rs", 32'(rs_out), 32'h3);
    check("lu_resume_bus_a", bus_a_out, 32'hAA);

    // Load-use via rt operand
    drive(CTRL_LW, 32'h204, 32'h0, 5'd2, 5'd9, 5'd0, 16'h14);
    step();
    drive(CTRL_ADD, 32'h1, 32'h2, 5'd4, 5'd9, 5'd8, 16'h0);
    check("lu_rt_stall", 32'(stall), 32'h1);
    step();
    check("lu_rt_count", 32'(count), 32'h2);

    // r0 exclusion
    drive(CTRL_LW, 32'h300, 32'h0, 5'd2, 5'd0, 5'd0, 16'h20);
    step();
    drive(CTRL_ADDI, 32'h77, 32'h0, 5'd0, 5'd7, 5'd0, 16'h1);
    check("r0_stall", 32'(stall), 32'h0);
    step();
    check("r0_ctrl", 32'(ctrl_out), 32'(CTRL_ADDI));
    check("r0_regs", {22'h0, rs_out, rt_out}, {22'h0, 5'd0, 5'd7});
    check("r0_count", 32'(count), 32'h2);

    // Flush during hazard
    drive(CTRL_LW, 32'h400, 32'h0, 5'd1, 5'd3, 5'd0, 16'h30);
    step();
    drive(CTRL_ADD, 32'hCC, 32'h0, 5'd3, 5'd5, 5'd6, 16'h0);
    flush = 1'b1;
    #1;
    check("flush_stall", 32'(stall), 32'h0);
    step();
    flush = 1'b0;
    check("flush_ctrl", 32'(ctrl_out), 32'h0);
    check("flush_bus_a", bus_a_out, 32'h0);
    check("flush_count", 32'(count), 32'h3);

    // Halt during hazard
    drive(CTRL_LW, 32'h500, 32'h0, 5'd1, 5'd3, 5'd0, 16'h40);
    step();
    drive(CTRL_ADD, 32'hDD, 32'h0, 5'd3, 5'd5, 5'd6, 16'h0);
    halt = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("halt_stall", 32'(stall), 32'h0);
      step();
      check("halt_ctrl", 32'(ctrl_out), 32'(CTRL_LW));
      check("halt_bus_a", bus_a_out, 32'h500);
      check("halt_count", 32'(count), 32'h3);
    end
    halt = 1'b0;
    #1;
    check("halt_release_stall", 32'(stall), 32'h1);
    step();
    check("halt_bubble_ctrl", 32'(ctrl_out), 32'h0);
    check("halt_bubble_count", 32'(count), 32'h4);
    check("halt_stall_once", 32'(stall), 32'h0);

    // Reset asserted mid-stall
    drive(CTRL_LW, 32'h600, 32'h0, 5'd1, 5'd3, 5'd0, 16'h50);
    step();
    drive(CTRL_ADD, 32'hEE, 32'h0, 5'd3, 5'd5, 5'd6, 16'h0);
    check("rst_mid_stall_pre", 32'(stall), 32'h1);
    reset = 1'b1;
    step();
    check("rst_mid_ctrl", 32'(ctrl_out), 32'h0);
    check("rst_mid_count", 32'(count), 32'h0);
    check("rst_mid_stall", 32'(stall), 32'h0);
    reset = 1'b0;

    // Saturation on the 4-bit counter instance
    drive(CTRL_ADDI, 32'h1, 32'h2, 5'd1, 5'd2, 5'd3, 16'h4);
    flush = 1'b1;
    for (int i = 0; i < 14; i++) step();
    check("sat_count_14", 32'(s_count), 32'hE);
    step();
    check("sat_count_15", 32'(s_count), 32'hF);
    step();
    step();
    check("sat_hold", 32'(s_count), 32'hF);
    check("sat_wide_count", 32'(count), 32'd17);
    flush = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
